lsu_ctrl: RTL and testbench

Load/store sequencer between the execute stage and the word-wide data memory. The memory always reads and writes 4 bytes, so this block turns RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into aligned word accesses. Sub-word stores use a read-modify-write sequence. The block checks alignment and funct3 legality and returns an extended load result, or an error, to the pipeline through a valid/ready handshake.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_align.sv | 61 ++++++
 rtl/lsu_ctrl.sv | 142 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store sequencer.
package lsu_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Sequencer state encoding
  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StRead  = 2'd1;
  localparam state_t StWrite = 2'd2;
  localparam state_t StResp  = 2'd3;

  // Byte lane within a 32-bit word
  typedef logic [1:0] lane_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath: request legality check, load extract/extend, store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        chk_we,
  input  logic [2:0]  chk_funct3,
  input  lane_t       chk_lane,
  output logic        chk_err,
  input  logic [2:0]  op_funct3,
  input  lane_t       op_lane,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{op_lane, 3'b000} +: 8];
  assign half_sel = op_lane[1] ? rdata[31:16] : rdata[15:0];

  // Misalignment and funct3 legality for the incoming request
  always_comb begin
    chk_err = 1'b1;
    case (chk_funct3)
      F3_B:    chk_err = 1'b0;
      F3_H:    chk_err = chk_lane[0];
      F3_W:    chk_err = (chk_lane != 2'b00);
      F3_BU:   chk_err = chk_we;
      F3_HU:   chk_err = chk_we | chk_lane[0];
      default: chk_err = 1'b1;
    endcase
  end

  // Select the addressed lane and sign/zero extend
  always_comb begin
    load_data = rdata;
    case (op_funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase
  end

  // Replace the addressed byte/half of the fetched word with store data
  always_comb begin
    merge_data = rdata;
    case (op_funct3)
      F3_B: merge_data[{op_lane, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (op_lane[1]) merge_data[31:16] = wdata[15:0];
        else            merge_data[15:0]  = wdata[15:0];
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: turns RV32I byte/half/word accesses into aligned word accesses,
// using read-modify-write for sub-word stores.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned RD_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned WaitW = (RD_WAIT > 0) ? $clog2(RD_WAIT + 1) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(RD_WAIT);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [31:0]       wword_q, wword_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic        chk_err;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  lsu_align u_align (
    .chk_we     (req_we),
    .chk_funct3 (req_funct3),
    .chk_lane   (req_addr[1:0]),
    .chk_err    (chk_err),
    .op_funct3  (f3_q),
    .op_lane    (addr_q[1:0]),
    .rdata      (mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Next-state: accept in idle, wait out the read, merge or extract, then respond
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wait_d  = wait_q;
    wword_d = wword_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wait_d  = '0;
          rdata_d = '0;
          err_d   = chk_err;
          if (chk_err) begin
            state_d = StResp;
          end else if (req_we && (req_funct3 == F3_W)) begin
            wword_d = req_wdata;
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (wait_q == WaitLast) begin
          if (we_q) begin
            wword_d = merge_data;
            state_d = StWrite;
          end else begin
            rdata_d = load_data;
            state_d = StResp;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      wait_q  <= '0;
      wword_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
      wword_q <= wword_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from state so reset kills a pending write at once
  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
    resp_rdata = rdata_q;
    resp_err   = err_q;
    mem_rw     = (state_q != StWrite);
    mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    mem_wdata  = wword_q;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl: two instances (RD_WAIT=0 and RD_WAIT=2) share stimulus and
// are compared against a byte-array reference model.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_err;
  logic [1:0]  mem_rw;
  logic [31:0] resp_rdata [2];
  logic [31:0] mem_addr   [2];
  logic [31:0] mem_wdata  [2];
  logic [31:0] mem_rdata  [2];

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(32), .RD_WAIT(0)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready[0]),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid[0]),
    .resp_rdata (resp_rdata[0]),
    .resp_err   (resp_err[0]),
    .mem_rw     (mem_rw[0]),
    .mem_addr   (mem_addr[0]),
    .mem_wdata  (mem_wdata[0]),
    .mem_rdata  (mem_rdata[0])
  );

  lsu_ctrl #(.ADDR_W(32), .RD_WAIT(2)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready[1]),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid[1]),
    .resp_rdata (resp_rdata[1]),
    .resp_err   (resp_err[1]),
    .mem_rw     (mem_rw[1]),
    .mem_addr   (mem_addr[1]),
    .mem_wdata  (mem_wdata[1]),
    .mem_rdata  (mem_rdata[1])
  );

  // Word memories, one per instance; 64 words aliased over the address space
  logic [31:0] mem       [2][64];
  logic [31:0] last_addr [2];
  int          age       [2];
  logic        mem_init;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_init) begin
        for (int k = 0; k < 64; k++)
          mem[d][k] <= {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
        age[d]       <= 0;
        last_addr[d] <= '0;
      end else begin
        if (!mem_rw[d]) mem[d][mem_addr[d][7:2]] <= mem_wdata[d];
        age[d]       <= (mem_addr[d] == last_addr[d]) ? age[d] + 1 : 1;
        last_addr[d] <= mem_addr[d];
      end
    end
  end

  // Slow memory only returns real data once the address has been held for two prior cycles
  always_comb begin
    mem_rdata[0] = mem[0][mem_addr[0][7:2]];
    mem_rdata[1] = ((mem_addr[1] == last_addr[1]) && (age[1] >= 2)) ?
                   mem[1][mem_addr[1][7:2]] : 32'hDEADBEEF;
  end

  // Reference byte memory
  logic [7:0] ref_mem [256];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic is_h, is_w, legal;
    is_h  = (f3 == 3'b001) || (f3 == 3'b101);
    is_w  = (f3 == 3'b010);
    legal = we ? (f3 <= 3'b010) : !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
    return !legal || (is_h && a[0]) || (is_w && (a[1:0] != 2'b00));
  endfunction

  // Issue one request to both instances and compare the whole transaction with the model
  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    logic        e;
    int          exp_lat [2];
    int          exp_wr;
    logic [31:0] exp_rd, exp_wword, aw;
    int          b, base, mx;
    int          lat [2], nresp [2], nwr [2], busy_rdy [2];
    logic [31:0] got_rd [2], got_wa [2], got_wd [2];
    logic        got_err [2];

    aw   = {a[31:2], 2'b00};
    b    = int'(a[7:0]);
    base = int'({a[7:2], 2'b00});
    e    = model_err(we, f3, a);
    exp_rd    = '0;
    exp_wr    = 0;
    exp_wword = '0;
    if (e) begin
      exp_lat[0] = 0;
      exp_lat[1] = 0;
    end else if (!we) begin
      exp_lat[0] = 1;
      exp_lat[1] = 3;
      case (f3)
        3'b000:  exp_rd = {{24{ref_mem[b][7]}}, ref_mem[b]};
        3'b100:  exp_rd = {24'h0, ref_mem[b]};
        3'b001:  exp_rd = {{16{ref_mem[b+1][7]}}, ref_mem[b+1], ref_mem[b]};
        3'b101:  exp_rd = {16'h0, ref_mem[b+1], ref_mem[b]};
        default: exp_rd = {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
      endcase
    end else begin
      exp_wr = 1;
      if (f3 == 3'b010) begin
        exp_lat[0] = 1;
        exp_lat[1] = 1;
        for (int i = 0; i < 4; i++) ref_mem[base+i] = wd[8*i +: 8];
      end else begin
        exp_lat[0] = 2;
        exp_lat[1] = 4;
        ref_mem[b] = wd[7:0];
        if (f3 == 3'b001) ref_mem[b+1] = wd[15:8];
      end
      exp_wword = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    end

    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("%s/d%0d/ready_before", tag, d), 32'(req_ready[d]), 32'd1);
      lat[d] = -1; nresp[d] = 0; nwr[d] = 0; busy_rdy[d] = 0;
      got_rd[d] = '0; got_wa[d] = '0; got_wd[d] = '0; got_err[d] = 1'b0;
    end

    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;

    for (int n = 0; n < 16; n++) begin
      for (int d = 0; d < 2; d++) begin
        if (nresp[d] == 0 && req_ready[d]) busy_rdy[d]++;
        if (resp_valid[d]) begin
          nresp[d]++;
          if (nresp[d] == 1) begin
            lat[d]     = n;
            got_rd[d]  = resp_rdata[d];
            got_err[d] = resp_err[d];
          end
        end
        if (!mem_rw[d]) begin
          nwr[d]++;
          got_wa[d] = mem_addr[d];
          got_wd[d] = mem_wdata[d];
        end
      end
      mx = (lat[0] > lat[1]) ? lat[0] : lat[1];
      if (nresp[0] > 0 && nresp[1] > 0 && n >= mx + 1) break;
      @(posedge clk);
      #1;
    end

    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("%s/d%0d/latency", tag, d), 32'(lat[d]), 32'(exp_lat[d]));
      check_eq($sformatf("%s/d%0d/pulses", tag, d), 32'(nresp[d]), 32'd1);
      check_eq($sformatf("%s/d%0d/err", tag, d), 32'(got_err[d]), 32'(e));
      check_eq($sformatf("%s/d%0d/rdata", tag, d), got_rd[d], exp_rd);
      check_eq($sformatf("%s/d%0d/writes", tag, d), 32'(nwr[d]), 32'(exp_wr));
      if (exp_wr == 1) begin
        check_eq($sformatf("%s/d%0d/waddr", tag, d), got_wa[d], aw);
        check_eq($sformatf("%s/d%0d/wdata", tag, d), got_wd[d], exp_wword);
      end
      check_eq($sformatf("%s/d%0d/ready_busy", tag, d), 32'(busy_rdy[d]), 32'd0);
      check_eq($sformatf("%s/d%0d/ready_after", tag, d), 32'(req_ready[d]), 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("%s/d%0d/ready", tag, d), 32'(req_ready[d]), 32'd1);
      check_eq($sformatf("%s/d%0d/resp_valid", tag, d), 32'(resp_valid[d]), 32'd0);
      check_eq($sformatf("%s/d%0d/resp_rdata", tag, d), resp_rdata[d], 32'd0);
      check_eq($sformatf("%s/d%0d/resp_err", tag, d), 32'(resp_err[d]), 32'd0);
      check_eq($sformatf("%s/d%0d/mem_rw", tag, d), 32'(mem_rw[d]), 32'd1);
      check_eq($sformatf("%s/d%0d/mem_addr", tag, d), mem_addr[d], 32'd0);
      check_eq($sformatf("%s/d%0d/mem_wdata", tag, d), mem_wdata[d], 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    int          r;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i);
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    mem_init   = 1'b1;
    #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    run_req("lw_4",     1'b0, 3'b010, 32'h0000_0004, 32'h0);
    run_req("lb_85",    1'b0, 3'b000, 32'h0000_0085, 32'h0);
    run_req("lbu_85",   1'b0, 3'b100, 32'h0000_0085, 32'h0);
    run_req("lh_86",    1'b0, 3'b001, 32'h0000_0086, 32'h0);
    run_req("lhu_86",   1'b0, 3'b101, 32'h0000_0086, 32'h0);
    run_req("sb_9",     1'b1, 3'b000, 32'h0000_0009, 32'h0000_00AA);
    run_req("lw_8",     1'b0, 3'b010, 32'h0000_0008, 32'h0);
    run_req("sw_10",    1'b1, 3'b010, 32'h0000_0010, 32'h1234_5678);
    run_req("lw_10",    1'b0, 3'b010, 32'h0000_0010, 32'h0);
    run_req("sh_hi",    1'b1, 3'b001, 32'h0000_0032, 32'hCAFE_BABE);
    run_req("lw_2",     1'b0, 3'b010, 32'h0000_0002, 32'h0);
    run_req("sh_3",     1'b1, 3'b001, 32'h0000_0003, 32'hFFFF);
    run_req("ld_f3_3",  1'b0, 3'b011, 32'h0000_0000, 32'h0);
    run_req("st_f3_4",  1'b1, 3'b100, 32'h0000_0000, 32'h55);
    run_req("lhu_odd",  1'b0, 3'b101, 32'h0000_0041, 32'h0);
    run_req("lw_top",   1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0);
    run_req("sw_top",   1'b1, 3'b010, 32'hFFFF_FFFC, 32'hA5A5_0F0F);
    run_req("lb_top",   1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0);

    // Reset during the read phase of a halfword RMW
    req_we     = 1'b1;
    req_funct3 = 3'b001;
    req_addr   = 32'h0000_0022;
    req_wdata  = 32'h0000_BEEF;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_rmw");
    @(posedge clk);
    #1;
    check_eq("rst_rmw/d0/mem_rw_hold", 32'(mem_rw[0]), 32'd1);
    check_eq("rst_rmw/d1/mem_rw_hold", 32'(mem_rw[1]), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_rmw/d0/ready_release", 32'(req_ready[0]), 32'd1);
    check_eq("rst_rmw/d1/ready_release", 32'(req_ready[1]), 32'd1);
    run_req("lw_after_rst", 1'b0, 3'b010, 32'h0000_0020, 32'h0);

    // Randomized traffic, mostly legal and aligned
    for (int it = 0; it < 120; it++) begin
      we = 1'($urandom);
      r  = int'($urandom_range(0, 9));
      if (r < 8) begin
        if (we) begin
          case ($urandom_range(0, 2))
            0:       f3 = 3'b000;
            1:       f3 = 3'b001;
            default: f3 = 3'b010;
          endcase
        end else begin
          case ($urandom_range(0, 4))
            0:       f3 = 3'b000;
            1:       f3 = 3'b001;
            2:       f3 = 3'b010;
            3:       f3 = 3'b100;
            default: f3 = 3'b101;
          endcase
        end
      end else begin
        f3 = 3'($urandom);
      end
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      run_req($sformatf("rnd%0d", it), we, f3, a, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
